ccu_conflict_gate: RTL and testbench

Admission stage directly upstream of the CCU's in-flight line tracker (a lookup FIFO keyed by cache-line address). Holds each incoming snoop/coherent request, looks up its line address in the tracker, and forwards it only when no in-flight transaction targets the same line and the tracker has room. On forwarding, it pushes the line address into the tracker in the same cycle. Optional saturating counters expose conflict-stall statistics.

---
 rtl/ccu_conflict_gate.sv | 122 ++++++++++++
 tb/tb_ccu_conflict_gate.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccu_conflict_gate.sv
// Admission gate in front of the CCU in-flight line tracker: holds one request and forwards it
// only when its line is not in flight and the tracker has room. Stall counters: CCU_CONFLICT_STATS_EN.
//
// state | meaning
// IDLE  | holding register empty
// CHECK | first cycle after capture, lookup in progress
// STALL | request held, blocked by line conflict or full tracker
module ccu_conflict_gate #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_OFFSET = 6,
  parameter int ID_WIDTH    = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [ADDR_WIDTH-1:0]             req_addr_i,
  input  logic [ID_WIDTH-1:0]               req_id_i,
  output logic                              fwd_valid_o,
  input  logic                              fwd_ready_i,
  output logic [ADDR_WIDTH-1:0]             fwd_addr_o,
  output logic [ID_WIDTH-1:0]               fwd_id_o,
  output logic [ADDR_WIDTH-LINE_OFFSET-1:0] lookup_line_o,
  input  logic                              lookup_match_i,
  output logic                              track_push_o,
  output logic [ADDR_WIDTH-LINE_OFFSET-1:0] track_line_o,
  input  logic                              track_full_i,
  output logic [CNT_WIDTH-1:0]              stall_cycles_o,
  output logic [CNT_WIDTH-1:0]              stall_events_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  go;
  logic                  handshake;

  assign go          = !lookup_match_i && !track_full_i;
  assign fwd_valid_o = (state_q != IDLE) && go;
  assign handshake   = fwd_valid_o && fwd_ready_i;
  assign req_ready_o = (state_q == IDLE) || handshake;
  assign track_push_o = handshake;

  // Tracker ports always see the held line, never the incoming address.
  assign fwd_addr_o    = addr_q;
  assign fwd_id_o      = id_q;
  assign lookup_line_o = addr_q[ADDR_WIDTH-1:LINE_OFFSET];
  assign track_line_o  = addr_q[ADDR_WIDTH-1:LINE_OFFSET];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) state_d = CHECK;
      end
      CHECK, STALL: begin
        if (handshake)  state_d = req_valid_i ? CHECK : IDLE;
        else if (!go)   state_d = STALL;
      end
      default: state_d = IDLE;
    endcase
    if (req_valid_i && req_ready_o) begin
      addr_d = req_addr_i;
      id_d   = req_id_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
    end
  end

`ifdef CCU_CONFLICT_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_WIDTH-1:0] stall_events_q, stall_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    stall_events_d = stall_events_q;
    if ((state_q != IDLE) && !go && !(&stall_cycles_q))
      stall_cycles_d = stall_cycles_q + CntOne;
    // An event is counted only once per request: on its first (CHECK) cycle.
    if ((state_q == CHECK) && !go && !(&stall_events_q))
      stall_events_d = stall_events_q + CntOne;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cycles_q <= '0;
      stall_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      stall_events_q <= stall_events_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign stall_events_o = stall_events_q;
`else
  assign stall_cycles_o = '0;
  assign stall_events_o = '0;
`endif

endmodule

// File: tb/tb_ccu_conflict_gate.sv
// Scoreboard bench for ccu_conflict_gate: directed stimulus pushes expected forwards,
// a negedge monitor pops and compares on every downstream handshake.
module tb_ccu_conflict_gate;
  localparam int AW = 32;
  localparam int LO = 6;
  localparam int IW = 4;
  localparam int CW = 16;
`ifdef CCU_CONFLICT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic [AW-1:0]    req_addr_i = '0;
  logic [IW-1:0]    req_id_i = '0;
  logic             fwd_valid_o;
  logic             fwd_ready_i = 1'b1;
  logic [AW-1:0]    fwd_addr_o;
  logic [IW-1:0]    fwd_id_o;
  logic [AW-LO-1:0] lookup_line_o;
  logic             lookup_match_i = 1'b0;
  logic             track_push_o;
  logic [AW-LO-1:0] track_line_o;
  logic             track_full_i = 1'b0;
  logic [CW-1:0]    stall_cycles_o;
  logic [CW-1:0]    stall_events_o;

  ccu_conflict_gate #(.ADDR_WIDTH(AW), .LINE_OFFSET(LO), .ID_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_id_i(req_id_i),
    .fwd_valid_o(fwd_valid_o), .fwd_ready_i(fwd_ready_i),
    .fwd_addr_o(fwd_addr_o), .fwd_id_o(fwd_id_o),
    .lookup_line_o(lookup_line_o), .lookup_match_i(lookup_match_i),
    .track_push_o(track_push_o), .track_line_o(track_line_o),
    .track_full_i(track_full_i),
    .stall_cycles_o(stall_cycles_o), .stall_events_o(stall_events_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
  } item_t;

  item_t    exp_q[$];
  int       checks = 0;
  int       failures = 0;
  int       hs_count = 0;
  int       cycle = 0;
  int       exp_cyc = 0;
  int       exp_ev = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk_i) cycle <= cycle + 1;

  // Monitor: every downstream handshake must match the oldest issued request.
  always @(negedge clk_i) begin
    if (rst_ni && fwd_valid_o && fwd_ready_i) begin
      item_t e;
      hs_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_forward", {32'd0, fwd_addr_o}, 64'hdead);
      end else begin
        e = exp_q.pop_front();
        chk("fwd_addr", fwd_addr_o, e.addr);
        chk("fwd_id", fwd_id_o, e.id);
        chk("track_push", track_push_o, 1'b1);
        chk("track_line", track_line_o, e.addr[AW-1:LO]);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [IW-1:0] id);
    item_t e;
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_id_i    = id;
    e.addr = a;
    e.id   = id;
    exp_q.push_back(e);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_stall_cycles"}, stall_cycles_o, STATS ? exp_cyc : 0);
    chk({tag, "_stall_events"}, stall_events_o, STATS ? exp_ev : 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int hs0;
    #12;
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_fwd_valid", fwd_valid_o, 1'b0);
    chk("rst_track_push", track_push_o, 1'b0);
    chk("rst_fwd_addr", fwd_addr_o, '0);
    chk("rst_lookup_line", lookup_line_o, '0);
    chk_counters("rst");
    rst_ni = 1'b1;
    step();

    // Single request, no conflict: forwarded in the first cycle after capture.
    issue(32'h1000, 4'd3);
    step();
    req_valid_i = 1'b0;
    #1;
    chk("t1_fwd_valid", fwd_valid_o, 1'b1);
    chk("t1_push", track_push_o, 1'b1);
    chk("t1_track_line", track_line_o, 26'h40);
    step();
    chk("t1_idle_valid", fwd_valid_o, 1'b0);
    chk("t1_idle_ready", req_ready_o, 1'b1);

    // Line conflict held for 5 cycles.
    issue(32'h2040, 4'd5);
    lookup_match_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    chk("t2_lookup_line", lookup_line_o, 26'h81);
    for (int i = 0; i < 5; i++) begin
      chk("t2_blocked_valid", fwd_valid_o, 1'b0);
      chk("t2_blocked_ready", req_ready_o, 1'b0);
      step();
    end
    exp_cyc += 5;
    exp_ev  += 1;
    lookup_match_i = 1'b0;
    #1;
    chk("t2_release_valid", fwd_valid_o, 1'b1);
    chk_counters("t2");
    step();

    // Tracker full for 3 cycles.
    issue(32'h3000, 4'd7);
    track_full_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_full_push", track_push_o, 1'b0);
      step();
    end
    exp_cyc += 3;
    exp_ev  += 1;
    track_full_i = 1'b0;
    #1;
    chk("t3_push_on_release", track_push_o, 1'b1);
    chk_counters("t3");
    step();

    // Downstream backpressure: valid held, data stable, no stall counted.
    issue(32'h4080, 4'd9);
    step();
    req_valid_i = 1'b0;
    fwd_ready_i = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_bp_valid", fwd_valid_o, 1'b1);
      chk("t4_bp_addr", fwd_addr_o, 32'h4080);
      chk("t4_bp_id", fwd_id_o, 4'd9);
      chk("t4_bp_ready", req_ready_o, 1'b0);
      chk("t4_bp_push", track_push_o, 1'b0);
      step();
    end
    chk_counters("t4");
    fwd_ready_i = 1'b1;
    step();

    // Stream of 8 distinct lines: 8 forwards in 9 cycles.
    c0  = cycle;
    hs0 = hs_count;
    for (int i = 0; i < 8; i++) begin
      issue(32'h5000 + 32'(i) * 32'h40, IW'(i));
      chk("t5_stream_ready", req_ready_o, 1'b1);
      step();
    end
    req_valid_i = 1'b0;
    step();
    chk("t5_stream_forwards", hs_count - hs0, 8);
    chk("t5_stream_cycles", cycle - c0, 9);

    // Same line back-to-back: second request blocks while the mock tracker holds the first.
    issue(32'h6000, 4'd1);
    step();
    issue(32'h6010, 4'd2);
    step();
    req_valid_i = 1'b0;
    lookup_match_i = 1'b1;
    #1;
    chk("t6_same_line_lookup", lookup_line_o, 26'h180);
    for (int i = 0; i < 2; i++) begin
      chk("t6_same_line_blocked", fwd_valid_o, 1'b0);
      step();
    end
    exp_cyc += 2;
    exp_ev  += 1;
    lookup_match_i = 1'b0;
    #1;
    chk("t6_same_line_release", fwd_valid_o, 1'b1);
    chk_counters("t6");
    step();

    // Reset while stalled: request discarded, nothing pushed.
    issue(32'h7000, 4'd4);
    lookup_match_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    step();
    rst_ni = 1'b0;
    void'(exp_q.pop_back());
    exp_cyc = 0;
    exp_ev  = 0;
    #2;
    rst_ni = 1'b1;
    lookup_match_i = 1'b0;
    #1;
    chk("t7_rst_valid", fwd_valid_o, 1'b0);
    chk("t7_rst_ready", req_ready_o, 1'b1);
    chk("t7_rst_push", track_push_o, 1'b0);
    chk("t7_rst_addr", fwd_addr_o, '0);
    chk_counters("t7");
    step();
    step();
    chk("t7_no_push_after", track_push_o, 1'b0);

    chk("total_forwards", hs_count, 14);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
